// File: rtl/ow_pkg.sv
// rtl/ow_pkg.sv - shared 1-Wire definitions: FSM states, default slot timings, timer width
// Contents: ow_state_t responder state enum, OW_CNT_W timer width (common with the master
// driver), and default cycle counts assuming a 4 MHz clock (0.25 us per cycle).
package ow_pkg;

   localparam int OW_CNT_W = 16;

   localparam int OW_RESET_MIN_CYCLES     = 1200;
   localparam int OW_PRESENCE_WAIT_CYCLES = 60;
   localparam int OW_PRESENCE_LEN_CYCLES  = 160;
   localparam int OW_SAMPLE_CYCLES        = 60;
   localparam int OW_READ_HOLD_CYCLES     = 60;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SLOT_WRITE,
      ST_SLOT_READ,
      ST_SLOT_END,
      ST_PRESENCE_WAIT,
      ST_PRESENCE_DRIVE
   } ow_state_t;

endpackage

// File: rtl/ow_slave_responder_if.sv
// rtl/ow_slave_responder_if.sv - user-side byte interface of the 1-Wire slave responder
// Signals: TX_DATA/TX_VALID/TX_READY byte offer for read slots, RX_DATA/RX_VALID received
// byte, RESET_SEEN reset-pulse strobe, BUSY state-not-idle flag.
// Modports: slave (the responder), master (device-emulation logic or bench).
interface ow_slave_responder_if;
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       RESET_SEEN;
   logic       BUSY;

   modport slave (
      input  TX_DATA, TX_VALID,
      output TX_READY, RX_DATA, RX_VALID, RESET_SEEN, BUSY
   );

   modport master (
      output TX_DATA, TX_VALID,
      input  TX_READY, RX_DATA, RX_VALID, RESET_SEEN, BUSY
   );
endinterface

// File: rtl/ow_line_sync.sv
// rtl/ow_line_sync.sv - 1-Wire pad synchronizer, optional glitch filter, edge detect
// Ports: clk, rst (async active-high), line_in (raw pad), line_s (synced level),
// fall/rise (one-cycle edge strobes of line_s).
// Macro OW_SLAVE_GLITCH_FILTER_EN: adds a 3-tap majority filter (+1 cycle edge latency).
module ow_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic line_s,
   output logic fall,
   output logic rise
);
   logic s1, s2, prev;

   // Flops reset to 1 (idle bus level) so no edge is reported coming out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= line_in;
         s2 <= s1;
      end
   end

`ifdef OW_SLAVE_GLITCH_FILTER_EN
   logic d1, d2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1 <= 1'b1;
         d2 <= 1'b1;
      end else begin
         d1 <= s2;
         d2 <= d1;
      end
   end

   // Majority of the newest three samples: a single-cycle pulse never wins the vote.
   assign line_s = (s2 & d1) | (s2 & d2) | (d1 & d2);
`else
   assign line_s = s2;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b1;
      else     prev <= line_s;
   end

   assign fall = prev & ~line_s;
   assign rise = ~prev & line_s;
endmodule

// File: rtl/ow_slave_responder.sv
// rtl/ow_slave_responder.sv - 1-Wire slave bit/byte engine: reset/presence, write and read slots
// Ports: OW_SLAVE_CLK clock, OW_SLAVE_RST async active-high reset, OW_SLAVE_LINE open-drain
// bus (driven 0 or z only), bus (ow_slave_responder_if.slave: TX byte offer, RX byte,
// RESET_SEEN, BUSY).
// Macro OW_SLAVE_GLITCH_FILTER_EN: enables the line glitch filter inside ow_line_sync.
module ow_slave_responder
   import ow_pkg::*;
#(
   parameter int RESET_MIN_CYCLES     = OW_RESET_MIN_CYCLES,
   parameter int PRESENCE_WAIT_CYCLES = OW_PRESENCE_WAIT_CYCLES,
   parameter int PRESENCE_LEN_CYCLES  = OW_PRESENCE_LEN_CYCLES,
   parameter int SAMPLE_CYCLES        = OW_SAMPLE_CYCLES,
   parameter int READ_HOLD_CYCLES     = OW_READ_HOLD_CYCLES
) (
   input  logic                    OW_SLAVE_CLK,
   input  logic                    OW_SLAVE_RST,
   inout  wire                     OW_SLAVE_LINE,
   ow_slave_responder_if.slave     bus
);
   localparam logic [OW_CNT_W-1:0] RESET_MIN_T = OW_CNT_W'(RESET_MIN_CYCLES);
   localparam logic [OW_CNT_W-1:0] PWAIT_T     = OW_CNT_W'(PRESENCE_WAIT_CYCLES);
   localparam logic [OW_CNT_W-1:0] PLEN_T      = OW_CNT_W'(PRESENCE_LEN_CYCLES);
   localparam logic [OW_CNT_W-1:0] SAMPLE_T    = OW_CNT_W'(SAMPLE_CYCLES);
   localparam logic [OW_CNT_W-1:0] HOLD_T      = OW_CNT_W'(READ_HOLD_CYCLES);

   ow_state_t           state;
   logic [OW_CNT_W-1:0] tmr;
   logic [OW_CNT_W-1:0] low_cnt;
   logic [2:0]          bit_cnt;
   logic [7:0]          rx_shift, rx_next, rx_data;
   logic [7:0]          tx_byte;
   logic                tx_loaded, drive, rx_valid, reset_seen;
   logic                line_s, fall, rise;
   logic                tx_ready, reset_qual;

   ow_line_sync u_sync (
      .clk     (OW_SLAVE_CLK),
      .rst     (OW_SLAVE_RST),
      .line_in (OW_SLAVE_LINE),
      .line_s  (line_s),
      .fall    (fall),
      .rise    (rise)
   );

   // drive is cleared by the async reset, so the pad releases without waiting for a clock.
   assign OW_SLAVE_LINE = drive ? 1'b0 : 1'bz;

   assign tx_ready       = (state == ST_IDLE) && !tx_loaded && (bit_cnt == 3'd0);
   assign bus.TX_READY   = tx_ready;
   assign bus.RX_DATA    = rx_data;
   assign bus.RX_VALID   = rx_valid;
   assign bus.RESET_SEEN = reset_seen;
   assign bus.BUSY       = (state != ST_IDLE);

   // The count is still valid on the rise cycle because it clears one clock later.
   assign reset_qual = rise && (low_cnt >= RESET_MIN_T);

   always_comb begin
      rx_next          = rx_shift;
      rx_next[bit_cnt] = line_s;
   end

   // Our own drive must never look like a master reset, so it holds the counter at zero.
   always_ff @(posedge OW_SLAVE_CLK or posedge OW_SLAVE_RST) begin
      if (OW_SLAVE_RST)            low_cnt <= '0;
      else if (drive || line_s)    low_cnt <= '0;
      else if (low_cnt != '1)      low_cnt <= low_cnt + 1'b1;
   end

   always_ff @(posedge OW_SLAVE_CLK or posedge OW_SLAVE_RST) begin
      if (OW_SLAVE_RST) begin
         state      <= ST_IDLE;
         tmr        <= '0;
         bit_cnt    <= 3'd0;
         rx_shift   <= 8'h00;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         reset_seen <= 1'b0;
         tx_byte    <= 8'h00;
         tx_loaded  <= 1'b0;
         drive      <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         reset_seen <= 1'b0;

         if (tx_ready && bus.TX_VALID) begin
            tx_byte   <= bus.TX_DATA;
            tx_loaded <= 1'b1;
         end

         if (reset_qual) begin
            // Reset qualification overrides every state and discards partial bytes.
            state      <= ST_PRESENCE_WAIT;
            tmr        <= 16'd1;
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_loaded  <= 1'b0;
            drive      <= 1'b0;
            reset_seen <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (fall) begin
                     tmr <= 16'd1;
                     // tx_loaded is the pre-handshake value, so a same-cycle offer is a write slot.
                     if (tx_loaded) begin
                        state <= ST_SLOT_READ;
                        drive <= ~tx_byte[bit_cnt];
                     end else begin
                        state <= ST_SLOT_WRITE;
                     end
                  end
               end
               ST_SLOT_WRITE: begin
                  if (tmr == SAMPLE_T) begin
                     rx_shift <= rx_next;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                     end
                     state <= ST_SLOT_END;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end
               ST_SLOT_READ: begin
                  if (tmr == HOLD_T) begin
                     drive   <= 1'b0;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) tx_loaded <= 1'b0;
                     state <= ST_SLOT_END;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end
               ST_SLOT_END: begin
                  if (line_s) state <= ST_IDLE;
               end
               ST_PRESENCE_WAIT: begin
                  if (tmr == PWAIT_T) begin
                     state <= ST_PRESENCE_DRIVE;
                     drive <= 1'b1;
                     tmr   <= 16'd1;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end
               ST_PRESENCE_DRIVE: begin
                  if (tmr == PLEN_T) begin
                     drive <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  drive <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ow_slave_responder.sv
// tb/tb_ow_slave_responder.sv - directed self-checking bench for ow_slave_responder
module tb_ow_slave_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic master_low = 1'b0;
   wire  ow_line;

   int total = 0;
   int bad = 0;
   int rx_pulses = 0;
   int rs_pulses = 0;

   typedef struct {
      logic       is_read;
      logic [7:0] data;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs[6];

   assign ow_line = master_low ? 1'b0 : 1'bz;
   pullup (ow_line);

   ow_slave_responder_if bus ();

   ow_slave_responder dut (
      .OW_SLAVE_CLK  (clk),
      .OW_SLAVE_RST  (rst),
      .OW_SLAVE_LINE (ow_line),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.RX_VALID)   rx_pulses += 1;
      if (bus.RESET_SEEN) rs_pulses += 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_bit(input logic b);
      master_low = 1'b1;
      tick(b ? 4 : 356);
      master_low = 1'b0;
      tick(b ? 396 : 44);
   endtask

   task automatic write_byte(input logic [7:0] d);
      for (int i = 0; i < 8; i++) write_bit(d[i]);
   endtask

   task automatic read_byte(output logic [7:0] d);
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         master_low = 1'b1;
         tick(4);
         master_low = 1'b0;
         tick(8);
         d[i] = (ow_line === 1'b0) ? 1'b0 : 1'b1;
         tick(388);
      end
   endtask

   task automatic offer_tx(input logic [7:0] d);
      int n;
      n = 0;
      while (bus.TX_READY !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      check("tx_ready_wait", {31'd0, bus.TX_READY}, 32'd1);
      bus.TX_DATA  = d;
      bus.TX_VALID = 1'b1;
      tick(1);
      bus.TX_VALID = 1'b0;
      check("tx_ready_drop", {31'd0, bus.TX_READY}, 32'd0);
   endtask

   task automatic reset_pulse();
      int s, lows, first;
      s = rs_pulses;
      master_low = 1'b1;
      tick(1800);
      master_low = 1'b0;
      lows = 0;
      first = -1;
      for (int i = 1; i <= 300; i++) begin
         tick(1);
         if (ow_line === 1'b0) begin
            lows++;
            if (first < 0) first = i;
         end
      end
      check("presence_len", lows, 160);
      check("presence_start", first, 63);
      check("reset_seen_once", rs_pulses - s, 1);
      check("busy_after_presence", {31'd0, bus.BUSY}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_line"},       {31'd0, ow_line === 1'b0 ? 1'b0 : 1'b1}, 32'd1);
      check({tag, "_tx_ready"},   {31'd0, bus.TX_READY},   32'd1);
      check({tag, "_rx_data"},    {24'd0, bus.RX_DATA},    32'h00);
      check({tag, "_rx_valid"},   {31'd0, bus.RX_VALID},   32'd0);
      check({tag, "_reset_seen"}, {31'd0, bus.RESET_SEEN}, 32'd0);
      check({tag, "_busy"},       {31'd0, bus.BUSY},       32'd0);
   endtask

   initial begin
      logic [7:0] rd;
      int s, n;
      logic busy_seen;

      vecs[0] = '{1'b0, 8'hCC, 8'hCC};
      vecs[1] = '{1'b0, 8'h00, 8'h00};
      vecs[2] = '{1'b0, 8'hFF, 8'hFF};
      vecs[3] = '{1'b1, 8'hA5, 8'hA5};
      vecs[4] = '{1'b1, 8'h3C, 8'h3C};
      vecs[5] = '{1'b0, 8'h81, 8'h81};

      bus.TX_DATA  = 8'h00;
      bus.TX_VALID = 1'b0;
      tick(3);
      check_reset_outputs("por");
      rst = 1'b0;
      tick(5);

      reset_pulse();

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].is_read) begin
            offer_tx(vecs[v].data);
            read_byte(rd);
            check($sformatf("read_byte_%0d", v), {24'd0, rd}, {24'd0, vecs[v].exp_byte});
            tick(2);
            check($sformatf("tx_ready_after_%0d", v), {31'd0, bus.TX_READY}, 32'd1);
         end else begin
            s = rx_pulses;
            write_byte(vecs[v].data);
            check($sformatf("rx_data_%0d", v), {24'd0, bus.RX_DATA}, {24'd0, vecs[v].exp_byte});
            check($sformatf("rx_valid_once_%0d", v), rx_pulses - s, 1);
         end
      end

      // Partial byte interrupted by a reset must leave no stale bits behind.
      write_bit(1'b1);
      write_bit(1'b1);
      write_bit(1'b1);
      reset_pulse();
      s = rx_pulses;
      write_byte(8'h44);
      check("rx_after_reset", {24'd0, bus.RX_DATA}, 32'h44);
      check("rx_after_reset_once", rx_pulses - s, 1);

      s = rx_pulses;
      master_low = 1'b1;
      tick(1);
      master_low = 1'b0;
      busy_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (bus.BUSY === 1'b1) busy_seen = 1'b1;
      end
`ifdef OW_SLAVE_GLITCH_FILTER_EN
      check("glitch_no_busy", {31'd0, busy_seen}, 32'd0);
      check("glitch_no_rx", rx_pulses - s, 0);
`else
      check("glitch_makes_slot", {31'd0, busy_seen}, 32'd1);
      check("glitch_no_rx", rx_pulses - s, 0);
      reset_pulse();
`endif

      // Async reset in the middle of the presence drive.
      master_low = 1'b1;
      tick(1800);
      master_low = 1'b0;
      n = 0;
      while (ow_line !== 1'b0 && n < 200) begin
         tick(1);
         n++;
      end
      check("presence_seen_before_rst", {31'd0, ow_line === 1'b0 ? 1'b1 : 1'b0}, 32'd1);
      tick(20);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid_presence");
      tick(2);
      rst = 1'b0;
      tick(5);
      check("idle_after_rst", {31'd0, bus.BUSY}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
